// File: rtl/dataram_lsu_if.sv
// Request/response bus between the MEM stage and the byte-lane data RAM.
// Each direction uses valid/ready, and at most one transaction is outstanding.
interface dataram_lsu_if #(
  parameter int ADDR = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [ADDR-1:0] req_addr;
  logic [2:0]      req_funct3;
  logic [31:0]     req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dataram_lsu.sv
// Byte-addressed data RAM with RV32 load/store sizing, built from four byte-lane arrays.
// It uses a single-outstanding valid/ready request/response and flags rejected accesses.
module dataram_lsu #(
  parameter int ADDR  = 32,
  parameter int DEPTH = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  dataram_lsu_if.slave bus
);
  localparam int IDX = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  state_t          state;
  logic            req_ready;
  logic            accept;
  logic            req_err;
  logic [ADDR-3:0] word_addr;
  logic [IDX-1:0]  idx;
  logic [1:0]      off;
  logic [2:0]      f3;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;
  logic            wr_en;
  logic [31:0]     rd_word;
  logic [2:0]      cap_f3;
  logic [1:0]      cap_off;
  logic            cap_zero;
  logic            rsp_err;
  logic [31:0]     rsp_rdata;

  assign word_addr = bus.req_addr[ADDR-1:2];
  assign idx       = bus.req_addr[IDX+1:2];
  assign off       = bus.req_addr[1:0];
  assign f3        = bus.req_funct3;

  assign req_ready = (state == IDLE) | bus.rsp_ready;
  assign accept    = bus.req_valid & req_ready;

  always_comb begin
    req_err = 1'b0;
    case (f3)
      F3_B, F3_BU: req_err = 1'b0;
      F3_H, F3_HU: req_err = off[0];
      F3_W:        req_err = (off != 2'b00);
      default:     req_err = 1'b1;
    endcase
    // Unsigned sizes exist only for loads.
    if (bus.req_write && f3[2]) req_err = 1'b1;
    if (word_addr >= (ADDR-2)'(DEPTH)) req_err = 1'b1;
  end

  // Store data is replicated across lanes so each lane picks its byte from a fixed position.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = bus.req_wdata;
    case (f3[1:0])
      2'd0: begin
        wr_be   = 4'b0001 << off;
        wr_data = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        wr_be   = off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.req_wdata[15:0]}};
      end
      default: wr_be = 4'b1111;
    endcase
  end

  assign wr_en = accept & bus.req_write & ~req_err;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // NOTE: RAM arrays and their read register have no reset so they map onto block RAM;
    // the read register is only observed through the reset-cleared response state.
    always_ff @(posedge clk) begin
      if (wr_en && wr_be[k]) mem[idx] <= wr_data[8*k +: 8];
      if (accept)            rd_q     <= mem[idx];
    end

    assign rd_word[8*k +: 8] = rd_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values no matter how the always_ff blocks are ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rsp_err  <= 1'b0;
      cap_f3   <= F3_W;
      cap_off  <= 2'b00;
      cap_zero <= 1'b1;
    end else if (accept) begin
      state    <= RESP;
      rsp_err  <= req_err;
      cap_f3   <= f3;
      cap_off  <= off;
      cap_zero <= bus.req_write | req_err;
    end else if (bus.rsp_ready) begin
      state   <= IDLE;
      rsp_err <= 1'b0;
    end
  end

  // Stores and rejected requests return zero. Loads are extracted from the captured lane word.
  always_comb begin
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    sel_b     = rd_word[{cap_off, 3'b000} +: 8];
    sel_h     = rd_word[{cap_off[1], 4'b0000} +: 16];
    rsp_rdata = 32'h0;
    if (state == RESP && !cap_zero) begin
      case (cap_f3)
        F3_B:    rsp_rdata = {{24{sel_b[7]}}, sel_b};
        F3_BU:   rsp_rdata = {24'h0, sel_b};
        F3_H:    rsp_rdata = {{16{sel_h[15]}}, sel_h};
        F3_HU:   rsp_rdata = {16'h0, sel_h};
        default: rsp_rdata = rd_word;
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
endmodule

// File: tb/tb_dataram_lsu.sv
// Directed bench for dataram_lsu: sizing, errors, backpressure, a random stream
// checked against a byte-array model, and asynchronous reset.
module tb_dataram_lsu;
  localparam int DEPTH = 65536;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dataram_lsu_if #(.ADDR(32)) bus();

  dataram_lsu #(.ADDR(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  mdl [64];
  exp_t        q [$];
  exp_t        e;
  logic        r_w;
  logic [31:0] r_a;
  logic [2:0]  r_f3;
  logic [31:0] r_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Call at a negedge. Issues one request, checks the response one cycle later, returns at a negedge.
  task automatic send(input string tag, input logic w, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_funct3 = f3;
    bus.req_wdata  = d;
    bus.rsp_ready  = 1'b1;
    #1 check({tag, ".ready"}, bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, ".valid"}, bus.rsp_valid, 1);
    check({tag, ".rdata"}, bus.rsp_rdata, exp_rd);
    check({tag, ".err"}, bus.rsp_err, exp_err);
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_load(input int b, input logic [2:0] f3);
    case (f3)
      3'd0:    return {{24{mdl[b][7]}}, mdl[b]};
      3'd4:    return {24'h0, mdl[b]};
      3'd1:    return {{16{mdl[b+1][7]}}, mdl[b+1], mdl[b]};
      3'd5:    return {16'h0, mdl[b+1], mdl[b]};
      default: return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_funct3 = 3'd0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset.valid", bus.rsp_valid, 0);
    check("reset.rdata", bus.rsp_rdata, 0);
    check("reset.err", bus.rsp_err, 0);
    check("reset.ready", bus.req_ready, 1);
    @(negedge clk);

    send("sw10",     1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 0);
    send("lw10",     0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 0);
    send("sb12",     1, 32'h12, 3'd0, 32'h000000A5, 32'h0, 0);
    send("lw10b",    0, 32'h10, 3'd2, 32'h0, 32'hDEA5BEEF, 0);
    send("lb12",     0, 32'h12, 3'd0, 32'h0, 32'hFFFFFFA5, 0);
    send("lbu12",    0, 32'h12, 3'd4, 32'h0, 32'h000000A5, 0);
    send("lh12",     0, 32'h12, 3'd1, 32'h0, 32'hFFFFDEA5, 0);
    send("lhu10",    0, 32'h10, 3'd5, 32'h0, 32'h0000BEEF, 0);
    send("lh10",     0, 32'h10, 3'd1, 32'h0, 32'hFFFFBEEF, 0);
    send("lb13",     0, 32'h13, 3'd0, 32'h0, 32'hFFFFFFDE, 0);
    send("sh11",     1, 32'h11, 3'd1, 32'h00001234, 32'h0, 1);
    send("sw12",     1, 32'h12, 3'd2, 32'h11111111, 32'h0, 1);
    send("sbu10",    1, 32'h10, 3'd4, 32'h22222222, 32'h0, 1);
    send("lw10c",    0, 32'h10, 3'd2, 32'h0, 32'hDEA5BEEF, 0);
    send("lw_range", 0, 32'(4 * DEPTH), 3'd2, 32'h0, 32'h0, 1);
    send("lw_top",   0, 32'(4 * DEPTH - 4), 3'd3, 32'h0, 32'h0, 1);
    send("f3_3",     0, 32'h10, 3'd3, 32'h0, 32'h0, 1);
    send("f3_6",     0, 32'h10, 3'd6, 32'h0, 32'h0, 1);

    // Backpressure: hold the response, then consume and accept in the same edge.
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_funct3 = 3'd2;
    bus.rsp_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_addr   = 32'h13;
    bus.req_funct3 = 3'd4;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.ready_low", bus.req_ready, 0);
      check("bp.hold_valid", bus.rsp_valid, 1);
      check("bp.hold_rdata", bus.rsp_rdata, 32'hDEA5BEEF);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1 check("bp.ready_high", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("bp.b2b1_valid", bus.rsp_valid, 1);
    check("bp.b2b1_rdata", bus.rsp_rdata, 32'h000000DE);
    bus.req_addr   = 32'h10;
    bus.req_funct3 = 3'd2;
    #1 check("bp.b2b_ready", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("bp.b2b2_valid", bus.rsp_valid, 1);
    check("bp.b2b2_rdata", bus.rsp_rdata, 32'hDEA5BEEF);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp.idle_valid", bus.rsp_valid, 0);
    check("bp.idle_rdata", bus.rsp_rdata, 0);

    // Random stream over words 0x100..0x13C against a byte-array model.
    for (int w = 0; w < 16; w++) begin
      logic [31:0] d;
      d = $urandom;
      {mdl[4*w+3], mdl[4*w+2], mdl[4*w+1], mdl[4*w]} = d;
      send("rnd.init", 1, 32'h100 + 32'(4 * w), 3'd2, d, 32'h0, 0);
    end
    begin
      int   acc = 0;
      int   rsp_cnt = 0;
      int   issued = 0;
      int   cyc = 0;
      logic pend = 1'b0;
      while ((issued < 100 || pend || q.size() != 0 || bus.rsp_valid) && cyc < 3000) begin
        if (!pend && issued < 100) begin
          int kind;
          int w;
          int o;
          kind = $urandom_range(0, 7);
          w    = $urandom_range(0, 15);
          o    = 0;
          case (kind)
            0: begin r_f3 = 3'd0; o = $urandom_range(0, 3); end
            1: begin r_f3 = 3'd1; o = 2 * $urandom_range(0, 1); end
            2: r_f3 = 3'd2;
            3: begin r_f3 = 3'd0; o = $urandom_range(0, 3); end
            4: begin r_f3 = 3'd1; o = 2 * $urandom_range(0, 1); end
            5: r_f3 = 3'd2;
            6: begin r_f3 = 3'd4; o = $urandom_range(0, 3); end
            default: begin r_f3 = 3'd5; o = 2 * $urandom_range(0, 1); end
          endcase
          r_w  = (kind < 3);
          r_a  = 32'h100 + 32'(4 * w + o);
          r_d  = $urandom;
          bus.req_write  = r_w;
          bus.req_addr   = r_a;
          bus.req_funct3 = r_f3;
          bus.req_wdata  = r_d;
          pend   = 1'b1;
          issued++;
        end
        bus.req_valid = pend;
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (bus.rsp_valid && bus.rsp_ready) begin
          check("rnd.expected_pending", 32'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("rnd.rdata", bus.rsp_rdata, e.rd);
            check("rnd.err", bus.rsp_err, e.err);
            rsp_cnt++;
          end
        end
        if (bus.req_valid && bus.req_ready) begin
          int b;
          b = int'(r_a - 32'h100);
          e.err = 1'b0;
          e.rd  = 32'h0;
          if (r_w) begin
            mdl[b] = r_d[7:0];
            if (r_f3 != 3'd0) mdl[b+1] = r_d[15:8];
            if (r_f3 == 3'd2) begin
              mdl[b+2] = r_d[23:16];
              mdl[b+3] = r_d[31:24];
            end
          end else begin
            e.rd = model_load(b, r_f3);
          end
          q.push_back(e);
          acc++;
          pend = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
      bus.req_valid = 1'b0;
      check("rnd.no_timeout", 32'(cyc < 3000), 1);
      check("rnd.accepts", acc, 100);
      check("rnd.rsp_count", rsp_cnt, acc);
    end

    // Reset while a response is pending, then confirm storage survived.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_funct3 = 3'd2;
    bus.rsp_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst.pre_valid", bus.rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.async_valid", bus.rsp_valid, 0);
    check("rst.async_rdata", bus.rsp_rdata, 0);
    check("rst.async_err", bus.rsp_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst.ready", bus.req_ready, 1);
    @(negedge clk);
    send("rst.lw10", 0, 32'h10, 3'd2, 32'h0, 32'hDEA5BEEF, 0);
    send("rst.lw100", 0, 32'h100, 3'd2, 32'h0, {mdl[3], mdl[2], mdl[1], mdl[0]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dataram_lsu.md
Name: dataram_lsu

Overview:
Second-generation data memory for the k11 RISC-V core. It replaces the word-only, write-or-read data RAM with a byte-addressed, byte-lane-enabled RAM. It performs RV32 load/store sizing: LB/LH/LW/LBU/LHU and SB/SH/SW. It sits behind the MEM stage and uses a valid/ready request and response handshake with a single outstanding transaction and error reporting.

Parameters:
ADDR, 32, width of the byte address.
DEPTH, 65536, number of 32-bit words stored. Valid word indices are 0..DEPTH-1.
IDX, $clog2(DEPTH), word-index width. This is a localparam and not overridable.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR  byte address
req_funct3  in  3  RV32 size code: 0=B, 1=H, 2=W, 4=BU, 5=HU
req_wdata  in  32  store data, right-aligned (bits [7:0] for SB, [15:0] for SH)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  load result, sign- or zero-extended
rsp_err  out  1  request was rejected; memory unchanged

Behaviour:
- Storage is organised as four byte-lane arrays of DEPTH x 8 bits. Lane k holds byte address offset k (little-endian). Contents are not reset or initialised.
- Handshake and acceptance:
  - Accept = req_valid & req_ready.
  - req_ready = !rsp_valid | rsp_ready. Response consumption and new acceptance may occur in the same cycle.
  - Exactly one response is produced per accepted request, including stores and errors.
- Latency: response appears the cycle after acceptance (rsp_valid rises at the next posedge).
- Response hold: while rsp_valid & !rsp_ready, rsp_valid, rsp_rdata and rsp_err hold stable. The RAM output register and the captured funct3/offset update only on accept.
- State is two-state: IDLE (rsp_valid=0) and RESP (rsp_valid=1).
  - IDLE -> RESP on accept.
  - RESP -> IDLE on rsp_ready & !accept.
  - RESP -> RESP on rsp_ready & accept, or on !rsp_ready.
- Errors are evaluated at accept. rsp_err=1 if any of the following holds:
  - req_funct3 is 3, 6 or 7;
  - req_funct3 is 3 or above with req_write=1 (unsigned store);
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - addr[ADDR-1:2] >= DEPTH.
- An errored store writes no lane. An errored load gives rsp_rdata=0.
- Store lane enables:
  - SB enables lane addr[1:0] with wdata[7:0].
  - SH enables lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW enables all lanes with wdata.
  - Disabled lanes are untouched. A store response has rsp_rdata=0, rsp_err=0.
- Load extraction:
  - The word read at the accepted index is extracted using the captured offset.
  - B: sign-extend byte [8*off +: 8].
  - BU: zero-extend that byte.
  - H/HU: half [16*off[1] +: 16], sign- or zero-extended respectively.
  - W: full word.
- rsp_rdata is 0 whenever rsp_valid=0.
- Only one access is accepted per cycle, so no read-during-write collision exists. A load following a store to the same word observes the stored data.
- Reset (asserted at any time, including mid-transaction):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE, req_ready=1 once rst_n deasserts.
  - A pending response is discarded.
  - A store accepted in the same edge as the reset assertion is not guaranteed.
- Address bits above IDX+1 are used only for the range check.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> store response rdata=0, err=0; load response rdata=0xDEADBEEF, each exactly 1 cycle after accept.
- After the above: SB addr 0x12 data 0x000000A5, then LW 0x10 -> 0xDEA5BEEF; LB 0x12 -> 0xFFFFFFA5; LBU 0x12 -> 0x000000A5; LH 0x12 -> 0xFFFFDEA5; LHU 0x10 -> 0x0000BEEF.
- SH addr 0x11 data 0x1234 -> err=1; a following LW 0x10 -> 0xDEA5BEEF (unchanged). LW addr 4*DEPTH -> err=1, rdata=0. funct3=3 load -> err=1.
- Backpressure: LW 0x10 accepted, hold rsp_ready=0 for 5 cycles while req_valid=1 -> req_ready=0, response stable at 0xDEA5BEEF. Raise rsp_ready -> response consumed and the next request accepted in the same cycle, with back-to-back responses and no gaps.
- Stream 100 random aligned SB/SH/SW/loads against a byte-array model with random rsp_ready -> every response matches the model, and the response count equals the accept count.
- Assert rst_n low while rsp_valid=1 -> rsp_valid=0, rsp_rdata=0 immediately (asynchronously). After release, a fresh LW returns previously stored data.
